tdpram_port_arbiter: RTL

- Multiplexes NUM_CH independent request channels onto one true-dual-port RAM port (master side of an XPM TDP RAM port).
- Uses round-robin arbitration, registered issue and a latency-matched read-return pipeline.
- Routes read data back to the originating channel.
- Lets several engines (descriptor fetch, DMA, CSR access) share one BRAM port at a throughput of one access per cycle.

---
 rtl/tdpram_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tdpram_port_arbiter.sv
// Round-robin arbiter sharing one TDP RAM port between NUM_CH request channels.
// Registered issue stage plus a latency-matched tag pipeline routes read data home.
module tdpram_port_arbiter #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned READ_LATENCY = 1,
    localparam int unsigned STROBE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_CH-1:0]                req_valid_i,
    output logic [NUM_CH-1:0]                req_ready_o,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     req_din_i,
    input  logic [NUM_CH*STROBE_WIDTH-1:0]   req_we_i,
    output logic [NUM_CH-1:0]                rsp_valid_o,
    output logic [DATA_WIDTH-1:0]            rsp_dout_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_din_o,
    output logic                             mem_en_o,
    output logic [STROBE_WIDTH-1:0]          mem_we_o,
    input  logic [DATA_WIDTH-1:0]            mem_dout_i
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]       grant_c;
    logic [CH_W-1:0]         grant_id_c;
    logic                    grant_found_c;
    logic                    accept_c;
    logic                    accept_rd_c;
    logic [ADDR_WIDTH-1:0]   sel_addr_c;
    logic [DATA_WIDTH-1:0]   sel_din_c;
    logic [STROBE_WIDTH-1:0] sel_we_c;

    logic                    mem_en_q, mem_en_d;
    logic [STROBE_WIDTH-1:0] mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;

    logic [READ_LATENCY:0]   pipe_vld_q;
    logic [CH_W-1:0]         pipe_id_q [READ_LATENCY+1];
    logic [NUM_CH-1:0]       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_dout_q, rsp_dout_d;

    // First valid channel at or above rr_ptr, wrapping modulo NUM_CH
    always_comb begin
        logic [CH_W-1:0] idx;
        grant_c       = '0;
        grant_id_c    = '0;
        grant_found_c = 1'b0;
        idx           = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((32'(rr_ptr_q) + i) % NUM_CH);
            if (!grant_found_c && req_valid_i[idx]) begin
                grant_found_c = 1'b1;
                grant_c[idx]  = 1'b1;
                grant_id_c    = idx;
            end
        end
    end

    always_comb begin
        sel_addr_c = '0;
        sel_din_c  = '0;
        sel_we_c   = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (grant_c[k]) begin
                sel_addr_c = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_din_c  = req_din_i[k*DATA_WIDTH +: DATA_WIDTH];
                sel_we_c   = req_we_i[k*STROBE_WIDTH +: STROBE_WIDTH];
            end
        end
    end

    assign accept_c    = grant_found_c & ~rst_i;
    assign accept_rd_c = accept_c & (sel_we_c == '0);
    assign req_ready_o = rst_i ? '0 : grant_c;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        mem_en_d    = accept_c;
        mem_we_d    = '0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rsp_valid_d = '0;
        rsp_dout_d  = rsp_dout_q;
        if (accept_c) begin
            rr_ptr_d   = CH_W'((32'(grant_id_c) + 32'd1) % NUM_CH);
            mem_we_d   = sel_we_c;
            mem_addr_d = sel_addr_c;
            mem_din_d  = sel_din_c;
        end
        // Tag leaving the pipeline lines up with the RAM's read data
        if (pipe_vld_q[READ_LATENCY]) begin
            rsp_valid_d = NUM_CH'(1) << pipe_id_q[READ_LATENCY];
            rsp_dout_d  = mem_dout_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            pipe_vld_q  <= '0;
            for (int unsigned s = 0; s <= READ_LATENCY; s++) begin
                pipe_id_q[s] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_dout_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            pipe_vld_q   <= {pipe_vld_q[READ_LATENCY-1:0], accept_rd_c};
            pipe_id_q[0] <= grant_id_c;
            for (int unsigned s = 1; s <= READ_LATENCY; s++) begin
                pipe_id_q[s] <= pipe_id_q[s-1];
            end
            rsp_valid_q  <= rsp_valid_d;
            rsp_dout_q   <= rsp_dout_d;
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_din_o   = mem_din_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dout_o  = rsp_dout_q;

endmodule
